vproc_dispatcher: RTL and testbench
===================================

Name: vproc_dispatcher

Overview:
- Sits between the vector decoder and the execution units (LSU, ALU, MUL, SLD, ELEM).
- Accepts one decoded instruction per cycle, allocates an in-flight ID, and tracks vector-register read and write hazards per ID.
- Routes each instruction through a one-entry output buffer to the unit named by its op_unit code.
- Handles UNIT_CFG pseudo-instructions itself: it drains all in-flight work, then pulses a commit.

Parameters:
- UNIT_CNT, 5, number of real units; indices equal op_unit encodings UNIT_LSU..UNIT_ELEM.
- ID_W, 3, width of in-flight ID; at most 2**ID_W instructions in flight.

Ports:
- clk_i  in  1  clock
- async_rst_ni  in  1  asynchronous active-low reset
- instr_valid_i  in  1  decoded instruction valid
- instr_ready_o  out  1  instruction accepted when valid&ready
- instr_unit_i  in  3  op_unit target
- instr_emul_i  in  2  cfg_emul register-group size
- instr_rs1_vreg_i / instr_rs1_addr_i  in  1/5  source 1 is a vreg, and its base address
- instr_rs2_vreg_i / instr_rs2_addr_i  in  1/5  source 2 is a vreg, and its base address
- instr_vd_vreg_i / instr_vd_addr_i  in  1/5  destination is a vreg, and its base address
- dispatch_valid_o  out  UNIT_CNT  one-hot valid toward units
- dispatch_ready_i  in  UNIT_CNT  per-unit ready
- dispatch_id_o  out  ID_W  ID of buffered instruction
- done_valid_i  in  1  a unit finished an instruction
- done_id_i  in  ID_W  ID of finished instruction
- cfg_commit_o  out  1  one-cycle pulse when a CFG instruction is accepted
- busy_o  out  1  any instruction in flight or buffered

Behaviour:
- Reset values:
  - all outputs 0; state RUN; next_id=0; inflight=0; all masks 0; buffer empty.
  - Reset mid-operation discards the buffer and all tracking; no done is expected afterwards.
- Group mask: for base address a and emul e, bits [a&~(2**e-1) +: 2**e] of a 32-bit vector. Operands with vreg=0 contribute 0.
- Per-ID table: rd_mask[id] (rs1|rs2 groups), wr_mask[id] (vd group), and a valid bit.
- Hazard test against registered table state; done_i in cycle N takes effect in N+1, with no bypass.
  - RAW: new reads & OR(wr_mask).
  - WAW/WAR: new writes & (OR(wr_mask) | OR(rd_mask)).
  - Hazard if either term is non-zero.
- Non-CFG accept condition (state RUN): valid[next_id]==0, no hazard, and (buffer empty, or buffer handshaking this cycle).
- On non-CFG accept:
  - write table entry next_id;
  - load buffer with unit and ID;
  - next_id wraps modulo 2**ID_W;
  - inflight increments.
- Dispatch timing:
  - dispatch_valid_o[unit] is asserted from the cycle after accept.
  - It holds stable until dispatch_ready_i[unit] is seen.
  - A buffer handshake and a new accept may occur in the same cycle, giving back-to-back dispatch.
- Done handling:
  - On done_valid_i, clear the valid bit and both masks of done_id_i; inflight decrements.
  - Done for an invalid ID is ignored.
  - Simultaneous accept and done nets inflight to unchanged.
- CFG:
  - In RUN, a valid CFG deasserts ready and moves to DRAIN.
  - In DRAIN, ready=1 only when inflight==0 and buffer empty. That cycle accepts, cfg_commit_o=1, and the state returns to RUN.
  - CFG consumes no ID and no dispatch.
- Full: inflight==2**ID_W forces ready=0. It also follows naturally from valid[next_id]; in-order ID reuse means an old slow ID stalls issue.
- An invalid op_unit code (>UNIT_CFG) is accepted and dropped: no ID, no dispatch.
- busy_o = (inflight!=0) | buffer_full.

Decomposition:
- vproc_pkg gains:
  - function vreg_group_mask(addr[4:0], cfg_emul) returning logic[31:0];
  - a packed dispatch_info struct {op_unit unit; logic [ID_W-1:0] id}, with a fixed max width of 4.
- One sub-module: vproc_hazard_table, holding the per-ID rd/wr masks, valid bits, set/clear ports and OR-reduced pending masks.
- The dispatcher keeps the FSM, ID counter, inflight counter and output buffer.

Test Plan:
- Independent stream:
  - Stimulus: ALU vd=v1, MUL vd=v2, SLD vd=v3, units always ready.
  - Response: dispatch_valid on bits 1, 2, 3 in consecutive cycles, IDs 0, 1, 2, ready never drops.
- RAW stall:
  - Stimulus: ALU vd=v4 (ID0), then ALU rs1=v4, with done_id=0 in cycle 5.
  - Response: second instruction held with ready=0; accepted in cycle 6 with ID1.
- Group overlap:
  - Stimulus: LSU vd=v8 emul=EMUL_4 (ID0), then MUL rs2=v11 emul=EMUL_1.
  - Response: stall until ID0 done; MUL rs2=v12 dispatches immediately.
- Backpressure:
  - Stimulus: dispatch_ready_i[UNIT_MUL]=0 for 4 cycles with two independent MUL instructions.
  - Response: dispatch_valid_o stays set with ID0 stable; second instruction accepted only in the cycle ready rises.
- Full/wrap:
  - Stimulus: 8 independent instructions, no done.
  - Response: ninth stalls; done_id=0 lets it issue as ID0.
- CFG drain:
  - Stimulus: 2 in flight, CFG arrives, dones at cycles 3 and 7.
  - Response: cfg_commit_o pulses in cycle 8 only; busy_o=0 that cycle; reset asserted mid-drain returns ready=1 for non-CFG and busy_o=0.

Source files
------------

// File: rtl/vproc_pkg.sv
// Shared types for the vector dispatcher: unit codes, register-group sizes,
// the buffered dispatch record, and the register-group mask helper.
package vproc_pkg;

   localparam int ID_MAX_W = 4;

   typedef enum logic [2:0] {
      UNIT_LSU  = 3'd0,
      UNIT_ALU  = 3'd1,
      UNIT_MUL  = 3'd2,
      UNIT_SLD  = 3'd3,
      UNIT_ELEM = 3'd4,
      UNIT_CFG  = 3'd5
   } op_unit;

   typedef enum logic [1:0] {
      EMUL_1 = 2'd0,
      EMUL_2 = 2'd1,
      EMUL_4 = 2'd2,
      EMUL_8 = 2'd3
   } cfg_emul;

   typedef struct packed {
      op_unit              unit;
      logic [ID_MAX_W-1:0] id;
   } dispatch_info;

   // One bit per vector register covered by the group that contains addr.
   function automatic logic [31:0] vreg_group_mask(input logic [4:0] addr, input cfg_emul emul);
      logic [5:0] size;
      logic [4:0] base;
      size = 6'd1 << emul;
      base = addr & ~(5'(size) - 5'd1);
      return ((32'd1 << size) - 32'd1) << base;
   endfunction

endpackage

// File: rtl/vproc_hazard_table.sv
// Per-ID record of vector registers read and written by in-flight
// instructions, with OR-reduced pending masks for hazard checks.
module vproc_hazard_table
   import vproc_pkg::*;
#(
   parameter int ID_W = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 set_en,
   input  logic [ID_W-1:0]      set_id,
   input  logic [31:0]          set_rd,
   input  logic [31:0]          set_wr,
   input  logic                 clr_en,
   input  logic [ID_W-1:0]      clr_id,
   output logic [2**ID_W-1:0]   valid,
   output logic                 clr_hit,
   output logic [31:0]          rd_pend,
   output logic [31:0]          wr_pend
);

   localparam int N = 2**ID_W;

   logic [N-1:0][31:0] rd_mask;
   logic [N-1:0][31:0] wr_mask;

   // A done for an ID that is not in flight is ignored.
   assign clr_hit = clr_en & valid[clr_id];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid   <= '0;
         rd_mask <= '0;
         wr_mask <= '0;
      end else begin
         if (clr_hit) begin
            valid[clr_id]   <= 1'b0;
            rd_mask[clr_id] <= '0;
            wr_mask[clr_id] <= '0;
         end
         if (set_en) begin
            valid[set_id]   <= 1'b1;
            rd_mask[set_id] <= set_rd;
            wr_mask[set_id] <= set_wr;
         end
      end
   end

   always_comb begin
      rd_pend = '0;
      wr_pend = '0;
      for (int i = 0; i < N; i++) begin
         rd_pend |= rd_mask[i];
         wr_pend |= wr_mask[i];
      end
   end

endmodule

// File: rtl/vproc_dispatcher.sv
// Accepts decoded vector instructions, assigns in-flight IDs, blocks on
// register hazards and hands each instruction to its unit via a one-entry buffer.
module vproc_dispatcher
   import vproc_pkg::*;
#(
   parameter int UNIT_CNT = 5,
   parameter int ID_W     = 3
) (
   input  logic                clk_i,
   input  logic                async_rst_ni,
   input  logic                instr_valid_i,
   output logic                instr_ready_o,
   input  logic [2:0]          instr_unit_i,
   input  logic [1:0]          instr_emul_i,
   input  logic                instr_rs1_vreg_i,
   input  logic [4:0]          instr_rs1_addr_i,
   input  logic                instr_rs2_vreg_i,
   input  logic [4:0]          instr_rs2_addr_i,
   input  logic                instr_vd_vreg_i,
   input  logic [4:0]          instr_vd_addr_i,
   output logic [UNIT_CNT-1:0] dispatch_valid_o,
   input  logic [UNIT_CNT-1:0] dispatch_ready_i,
   output logic [ID_W-1:0]     dispatch_id_o,
   input  logic                done_valid_i,
   input  logic [ID_W-1:0]     done_id_i,
   output logic                cfg_commit_o,
   output logic                busy_o
);

   localparam int N = 2**ID_W;

   typedef enum logic {RUN, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [ID_W-1:0] next_id;
   logic [ID_W:0]   inflight;
   logic          buf_full;
   dispatch_info  buf_info;
   logic [N-1:0]  id_valid;
   logic          clr_hit, hazard, is_cfg, is_bad, hs, issue;
   logic [31:0]   rd_pend, wr_pend, rd_new, wr_new;
   logic          unused_id_bits;

   cfg_emul emul;
   assign emul = cfg_emul'(instr_emul_i);

   assign rd_new = (instr_rs1_vreg_i ? vreg_group_mask(instr_rs1_addr_i, emul) : 32'd0)
                 | (instr_rs2_vreg_i ? vreg_group_mask(instr_rs2_addr_i, emul) : 32'd0);
   assign wr_new = instr_vd_vreg_i ? vreg_group_mask(instr_vd_addr_i, emul) : 32'd0;

   assign hazard = |(rd_new & wr_pend) | |(wr_new & (wr_pend | rd_pend));
   assign is_cfg = instr_unit_i == UNIT_CFG;
   assign is_bad = instr_unit_i > UNIT_CFG;
   assign hs     = buf_full & dispatch_ready_i[buf_info.unit];

   vproc_hazard_table #(.ID_W(ID_W)) u_table (
      .clk     (clk_i),
      .rst_n   (async_rst_ni),
      .set_en  (issue),
      .set_id  (next_id),
      .set_rd  (rd_new),
      .set_wr  (wr_new),
      .clr_en  (done_valid_i),
      .clr_id  (done_id_i),
      .valid   (id_valid),
      .clr_hit (clr_hit),
      .rd_pend (rd_pend),
      .wr_pend (wr_pend)
   );

   // Unknown unit codes are swallowed in RUN without an ID or dispatch.
   always_comb begin
      state_nxt     = state;
      instr_ready_o = 1'b0;
      cfg_commit_o  = 1'b0;
      issue         = 1'b0;
      case (state)
         RUN: begin
            if (is_cfg) begin
               if (instr_valid_i) state_nxt = DRAIN;
            end else if (is_bad) begin
               instr_ready_o = 1'b1;
            end else begin
               instr_ready_o = ~id_valid[next_id] & ~hazard & (~buf_full | hs)
                             & (inflight != N[ID_W:0]);
               issue         = instr_valid_i & instr_ready_o;
            end
         end
         DRAIN: begin
            instr_ready_o = (inflight == '0) & ~buf_full;
            if (instr_valid_i & instr_ready_o) begin
               cfg_commit_o = 1'b1;
               state_nxt    = RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         state    <= RUN;
         next_id  <= '0;
         inflight <= '0;
         buf_full <= 1'b0;
         buf_info <= '0;
      end else begin
         state <= state_nxt;
         if (issue) next_id <= next_id + 1'b1;
         case ({issue, clr_hit})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: ;
         endcase
         if (issue) begin
            buf_full      <= 1'b1;
            buf_info.unit <= op_unit'(instr_unit_i);
            buf_info.id   <= ID_MAX_W'(next_id);
         end else if (hs) begin
            buf_full <= 1'b0;
         end
      end
   end

   always_comb begin
      dispatch_valid_o = '0;
      if (buf_full) dispatch_valid_o[buf_info.unit] = 1'b1;
   end

   assign dispatch_id_o  = buf_info.id[ID_W-1:0];
   assign busy_o         = (inflight != '0) | buf_full;
   assign unused_id_bits = ^buf_info.id;

endmodule

// File: tb/tb_vproc_dispatcher.sv
// Directed and randomized checks of vproc_dispatcher against a reference
// model built from per-ID register sets and the group rules.
module tb_vproc_dispatcher;
   import vproc_pkg::*;

   localparam int N = 8;

   logic       clk = 1'b0;
   logic       async_rst_ni = 1'b0;
   logic       instr_valid_i = 1'b0;
   logic       instr_ready_o;
   logic [2:0] instr_unit_i = '0;
   logic [1:0] instr_emul_i = '0;
   logic       instr_rs1_vreg_i = 1'b0, instr_rs2_vreg_i = 1'b0, instr_vd_vreg_i = 1'b0;
   logic [4:0] instr_rs1_addr_i = '0, instr_rs2_addr_i = '0, instr_vd_addr_i = '0;
   logic [4:0] dispatch_valid_o;
   logic [4:0] dispatch_ready_i = '1;
   logic [2:0] dispatch_id_o;
   logic       done_valid_i = 1'b0;
   logic [2:0] done_id_i = '0;
   logic       cfg_commit_o, busy_o;

   always #5 clk = ~clk;

   vproc_dispatcher dut (
      .clk_i(clk), .async_rst_ni(async_rst_ni),
      .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
      .instr_unit_i(instr_unit_i), .instr_emul_i(instr_emul_i),
      .instr_rs1_vreg_i(instr_rs1_vreg_i), .instr_rs1_addr_i(instr_rs1_addr_i),
      .instr_rs2_vreg_i(instr_rs2_vreg_i), .instr_rs2_addr_i(instr_rs2_addr_i),
      .instr_vd_vreg_i(instr_vd_vreg_i), .instr_vd_addr_i(instr_vd_addr_i),
      .dispatch_valid_o(dispatch_valid_o), .dispatch_ready_i(dispatch_ready_i),
      .dispatch_id_o(dispatch_id_o), .done_valid_i(done_valid_i), .done_id_i(done_id_i),
      .cfg_commit_o(cfg_commit_o), .busy_o(busy_o)
   );

   int vectors = 0, miscompares = 0;

   // Reference state: which IDs are live and the registers each one touches.
   bit          m_val[N];
   logic [31:0] m_rd[N], m_wr[N];
   int          m_next, m_bunit, m_bid;
   bit          m_bfull, m_drain;

   // Observations from the most recent step.
   bit obs_acc, obs_rdy, obs_commit, obs_busy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Registers sharing a group index with addr belong to its group.
   function automatic logic [31:0] grp(input int a, input int e);
      int sz;
      sz = 1 << e;
      grp = '0;
      for (int r = 0; r < 32; r++) if (r / sz == a / sz) grp[r] = 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin m_val[i] = 0; m_rd[i] = 0; m_wr[i] = 0; end
      m_next = 0; m_bfull = 0; m_bunit = 0; m_bid = 0; m_drain = 0;
   endtask

   task automatic drive(input int unit, input int emul, input bit r1v, input int r1,
                        input bit r2v, input int r2, input bit vdv, input int vd);
      instr_valid_i = 1'b1;
      instr_unit_i = 3'(unit); instr_emul_i = 2'(emul);
      instr_rs1_vreg_i = r1v; instr_rs1_addr_i = 5'(r1);
      instr_rs2_vreg_i = r2v; instr_rs2_addr_i = 5'(r2);
      instr_vd_vreg_i = vdv; instr_vd_addr_i = 5'(vd);
   endtask

   // One clock: check outputs against the model mid-cycle, then advance the model.
   task automatic step();
      bit exp_rdy, hs, acc;
      int inf, u;
      logic [31:0] orr, orw, rdm, wrm;
      @(negedge clk);
      inf = 0; orr = 0; orw = 0;
      for (int i = 0; i < N; i++) if (m_val[i]) begin inf++; orr |= m_rd[i]; orw |= m_wr[i]; end
      rdm = (instr_rs1_vreg_i ? grp(int'(instr_rs1_addr_i), int'(instr_emul_i)) : 32'd0)
          | (instr_rs2_vreg_i ? grp(int'(instr_rs2_addr_i), int'(instr_emul_i)) : 32'd0);
      wrm = instr_vd_vreg_i ? grp(int'(instr_vd_addr_i), int'(instr_emul_i)) : 32'd0;
      u = int'(instr_unit_i);
      hs = m_bfull && dispatch_ready_i[m_bunit];
      if (m_drain)     exp_rdy = (inf == 0) && !m_bfull;
      else if (u == 5) exp_rdy = 0;
      else if (u > 5)  exp_rdy = 1;
      else exp_rdy = !m_val[m_next] && ((rdm & orw) == 0) && ((wrm & (orw | orr)) == 0)
                     && (!m_bfull || hs);
      acc = instr_valid_i && exp_rdy;
      chk("ready", instr_ready_o, exp_rdy);
      chk("disp_valid", dispatch_valid_o, m_bfull ? (32'd1 << m_bunit) : 32'd0);
      if (m_bfull) chk("disp_id", dispatch_id_o, m_bid);
      chk("busy", busy_o, (inf != 0) || m_bfull);
      chk("cfg_commit", cfg_commit_o, m_drain && acc);
      obs_rdy = instr_ready_o; obs_acc = instr_valid_i && instr_ready_o;
      obs_commit = cfg_commit_o; obs_busy = busy_o;
      @(posedge clk);
      if (done_valid_i && m_val[done_id_i]) begin
         m_val[done_id_i] = 0; m_rd[done_id_i] = 0; m_wr[done_id_i] = 0;
      end
      if (hs) m_bfull = 0;
      if (m_drain) begin
         if (acc) m_drain = 0;
      end else if (u == 5) begin
         if (instr_valid_i) m_drain = 1;
      end else if (acc && u < 5) begin
         m_val[m_next] = 1; m_rd[m_next] = rdm; m_wr[m_next] = wrm;
         m_bfull = 1; m_bunit = u; m_bid = m_next;
         m_next = (m_next + 1) % N;
      end
      #1;
   endtask

   task automatic send(input int unit, input int emul, input bit r1v, input int r1,
                       input bit r2v, input int r2, input bit vdv, input int vd);
      int k;
      k = 0;
      drive(unit, emul, r1v, r1, r2v, r2, vdv, vd);
      do begin step(); k++; end while (!obs_acc && k < 60);
      chk("send_accept", obs_acc, 1);
      instr_valid_i = 1'b0;
   endtask

   task automatic done(input int id);
      done_valid_i = 1'b1; done_id_i = 3'(id);
      step();
      done_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      instr_valid_i = 1'b0; done_valid_i = 1'b0; dispatch_ready_i = '1;
      @(negedge clk);
      async_rst_ni = 1'b0;
      #1;
      chk("rst_disp_valid", dispatch_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_commit", cfg_commit_o, 0);
      chk("rst_disp_id", dispatch_id_o, 0);
      model_reset();
      @(posedge clk);
      #1 async_rst_ni = 1'b1;
   endtask

   initial begin
      bit holding;
      int live[$];

      model_reset();
      do_reset();

      // Independent stream: back-to-back issue to ALU, MUL, SLD.
      send(UNIT_ALU, 0, 0, 0, 0, 0, 1, 1);
      chk("indep_id0", dispatch_id_o, 0);
      send(UNIT_MUL, 0, 0, 0, 0, 0, 1, 2);
      chk("indep_id1", dispatch_id_o, 1);
      chk("indep_rdy1", obs_rdy, 1);
      send(UNIT_SLD, 0, 0, 0, 0, 0, 1, 3);
      chk("indep_id2", dispatch_id_o, 2);
      chk("indep_rdy2", obs_rdy, 1);
      step();
      done(0); done(1); done(2); step();

      // RAW stall: the dependent read waits until the done has landed.
      do_reset();
      send(UNIT_ALU, 0, 0, 0, 0, 0, 1, 4);
      drive(UNIT_ALU, 0, 1, 4, 0, 0, 0, 0);
      step(); chk("raw_stall_a", obs_rdy, 0);
      step(); chk("raw_stall_b", obs_rdy, 0);
      done_valid_i = 1'b1; done_id_i = 3'd0;
      step(); chk("raw_stall_done_cycle", obs_rdy, 0);
      done_valid_i = 1'b0;
      step(); chk("raw_accept", obs_acc, 1);
      chk("raw_id", dispatch_id_o, 1);
      instr_valid_i = 1'b0; step();

      // Group overlap: v8..v11 written by ID0 blocks v11 but not v12.
      do_reset();
      send(UNIT_LSU, EMUL_4, 0, 0, 0, 0, 1, 8);
      drive(UNIT_MUL, EMUL_1, 0, 0, 1, 11, 0, 0);
      step(); chk("grp_stall_a", obs_rdy, 0);
      step(); chk("grp_stall_b", obs_rdy, 0);
      drive(UNIT_MUL, EMUL_1, 0, 0, 1, 12, 0, 0);
      step(); chk("grp_free_accept", obs_acc, 1);
      drive(UNIT_MUL, EMUL_1, 0, 0, 1, 11, 0, 0);
      step(); chk("grp_stall_c", obs_rdy, 0);
      done_valid_i = 1'b1; done_id_i = 3'd0;
      step(); done_valid_i = 1'b0;
      step(); chk("grp_after_done", obs_acc, 1);
      instr_valid_i = 1'b0; step();

      // Backpressure: MUL unit stalled, buffered ID0 holds steady.
      do_reset();
      dispatch_ready_i[UNIT_MUL] = 1'b0;
      send(UNIT_MUL, 0, 0, 0, 0, 0, 1, 1);
      drive(UNIT_MUL, 0, 0, 0, 0, 0, 1, 2);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_stall", obs_rdy, 0);
         chk("bp_hold_id", dispatch_id_o, 0);
      end
      dispatch_ready_i[UNIT_MUL] = 1'b1;
      step(); chk("bp_accept_on_ready", obs_acc, 1);
      chk("bp_next_id", dispatch_id_o, 1);
      instr_valid_i = 1'b0; step();

      // Full and wrap: eight live IDs block the ninth until ID0 retires.
      do_reset();
      for (int i = 0; i < 8; i++) send(i % 5, 0, 0, 0, 0, 0, 1, i + 1);
      drive(UNIT_ALU, 0, 0, 0, 0, 0, 1, 20);
      step(); chk("full_stall_a", obs_rdy, 0);
      step(); chk("full_stall_b", obs_rdy, 0);
      done_valid_i = 1'b1; done_id_i = 3'd0;
      step(); done_valid_i = 1'b0;
      step(); chk("wrap_accept", obs_acc, 1);
      chk("wrap_id", dispatch_id_o, 0);
      instr_valid_i = 1'b0; step();

      // CFG drain: commit lands the cycle after the last done.
      do_reset();
      send(UNIT_ALU, 0, 0, 0, 0, 0, 1, 1);
      send(UNIT_ALU, 0, 0, 0, 0, 0, 1, 2);
      drive(UNIT_CFG, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 8; c++) begin
         done_valid_i = (c == 3 || c == 7);
         done_id_i = (c == 3) ? 3'd0 : 3'd1;
         step();
         chk($sformatf("cfg_commit_c%0d", c), obs_commit, c == 8);
         if (c == 8) chk("cfg_busy_at_commit", obs_busy, 0);
      end
      done_valid_i = 1'b0; instr_valid_i = 1'b0;
      step();

      // Reset in the middle of a drain clears everything.
      send(UNIT_ALU, 0, 0, 0, 0, 0, 1, 3);
      drive(UNIT_CFG, 0, 0, 0, 0, 0, 0, 0);
      step(); step();
      do_reset();
      drive(UNIT_ALU, 0, 0, 0, 0, 0, 1, 5);
      step(); chk("rst_drain_ready", obs_rdy, 1);
      instr_valid_i = 1'b0;
      step(); step(); done(0); step();
      chk("rst_drain_idle", busy_o, 0);

      // Randomized traffic with held requests, random dones and backpressure.
      do_reset();
      holding = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!holding) begin
            if ($urandom_range(0, 9) < 6) begin
               int u;
               u = $urandom_range(0, 15);
               u = (u < 13) ? u % 5 : ((u == 13) ? 5 : 6 + u % 2);
               drive(u, $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 31),
                     1'($urandom), $urandom_range(0, 31), 1'($urandom), $urandom_range(0, 31));
               holding = 1;
            end else instr_valid_i = 1'b0;
         end
         live.delete();
         for (int i = 0; i < N; i++) if (m_val[i] && !(m_bfull && m_bid == i)) live.push_back(i);
         done_valid_i = 1'b0;
         if (live.size() > 0 && $urandom_range(0, 9) < 4) begin
            done_valid_i = 1'b1;
            done_id_i = 3'(live[$urandom_range(0, live.size() - 1)]);
         end else if ($urandom_range(0, 19) == 0) begin
            done_valid_i = 1'b1;
            done_id_i = 3'($urandom);
         end
         dispatch_ready_i = 5'($urandom) | 5'($urandom);
         step();
         if (obs_acc) holding = 0;
      end
      instr_valid_i = 1'b0; done_valid_i = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
